// File: rtl/gru_sequencer.sv
// ---------------------------------------------------------------------------
// gru_sequencer
// Recurrence controller that walks a combinational-input GRU cell over a
// time series of SEQ_LEN input vectors. One vector is accepted per timestep
// on a valid/ready handshake and held on cell_x_t. The stored hidden state is
// held on cell_h_prev. CELL_LATENCY cycles after acceptance, the cell result
// is captured as the new hidden state. After SEQ_LEN steps, that state is
// offered on h_out until the consumer takes it.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   in_valid     x_in carries a timestep
//   in_ready     sequencer can accept a timestep (decoded from state)
//   x_in         input vector, WIDTH x [0:x_SIZE-1]
//   cell_x_t     to cell x_t (registered)
//   cell_h_prev  to cell h_t_minus_1 (registered)
//   cell_h_t     from cell h_t, sampled CELL_LATENCY cycles after acceptance
//   out_valid    h_out holds the final hidden state (decoded from state)
//   out_ready    consumer accepts h_out
//   h_out        final hidden state (same register as cell_h_prev)
//   step         completed timesteps in the current sequence, 0..SEQ_LEN
// ---------------------------------------------------------------------------
module gru_sequencer #(
    parameter int WIDTH        = 32,
    parameter int NFRAC        = 10,
    parameter int x_SIZE       = 32,
    parameter int h_SIZE       = 32,
    parameter int SEQ_LEN      = 8,
    parameter int CELL_LATENCY = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 x_in        [0:x_SIZE-1],
    output logic [WIDTH-1:0]                 cell_x_t    [0:x_SIZE-1],
    output logic [WIDTH-1:0]                 cell_h_prev [0:h_SIZE-1],
    input  logic [WIDTH-1:0]                 cell_h_t    [0:h_SIZE-1],
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 h_out       [0:h_SIZE-1],
    output logic [$clog2(SEQ_LEN+1)-1:0]     step
);

    localparam int STEP_W = $clog2(SEQ_LEN + 1);
    localparam int LAT_W  = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(CELL_LATENCY - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // NFRAC only describes the number format; it must leave an integer part.
    if (SEQ_LEN < 1 || CELL_LATENCY < 1 || NFRAC >= WIDTH) begin : g_param_check
        $error("gru_sequencer: illegal parameter set");
    end

    logic [1:0]        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [WIDTH-1:0]  x_reg [0:x_SIZE-1];
    logic [WIDTH-1:0]  h_reg [0:h_SIZE-1];

    // Handshake flags depend on state only, so there is no combinational
    // path from in_valid or out_ready to the outputs.
    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_OUT);
    assign cell_x_t    = x_reg;
    assign cell_h_prev = h_reg;
    assign h_out       = h_reg;

    // Sequencer FSM with operand, hidden-state, latency and step registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            step    <= '0;
            for (int i = 0; i < x_SIZE; i++) x_reg[i] <= '0;
            for (int i = 0; i < h_SIZE; i++) h_reg[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg   <= x_in;
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // x_reg and h_reg stay untouched here so the cell sees
                    // steady operands for its whole pipeline.
                    if (lat_cnt == '0) begin
                        h_reg <= cell_h_t;
                        step  <= step + STEP_ONE;
                        state <= (step == LAST_STEP) ? S_OUT : S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_ONE;
                    end
                end
                S_OUT: begin
                    // Clearing h_reg here starts the next sequence from h=0.
                    if (out_ready) begin
                        for (int i = 0; i < h_SIZE; i++) h_reg[i] <= '0;
                        step  <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gru_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gru_sequencer
// Drives gru_sequencer with a behavioural cell stub (h_t = h_prev + x_t,
// visible CELL_LATENCY cycles after its inputs settle). The reference model
// holds the hidden state as the running wrap-around sum of accepted inputs.
// Handshake and output timing are predicted from cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_gru_sequencer;

    localparam int W   = 16;
    localparam int N   = 8;
    localparam int SL  = 4;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] x_in        [0:N-1];
    logic [W-1:0] cell_x_t    [0:N-1];
    logic [W-1:0] cell_h_prev [0:N-1];
    logic [W-1:0] cell_h_t    [0:N-1];
    logic [W-1:0] h_out       [0:N-1];
    logic [2:0]   step;

    logic [W-1:0] pipe1 [0:N-1];
    logic [W-1:0] pipe2 [0:N-1];
    logic [W-1:0] mdl_h [0:N-1];
    int           mdl_step = 0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    gru_sequencer #(
        .WIDTH(W), .NFRAC(12), .x_SIZE(N), .h_SIZE(N),
        .SEQ_LEN(SL), .CELL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .cell_x_t(cell_x_t), .cell_h_prev(cell_h_prev), .cell_h_t(cell_h_t),
        .out_valid(out_valid), .out_ready(out_ready), .h_out(h_out),
        .step(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cell stub: LAT-1 register stages, so a result computed from operands
    // that settled after edge T is visible when sampled at edge T+LAT.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            pipe1[i] <= cell_h_prev[i] + cell_x_t[i];
            pipe2[i] <= pipe1[i];
        end
    end
    assign cell_h_t = pipe2;

    task automatic mdl_clear();
        for (int i = 0; i < N; i++) mdl_h[i] = '0;
        mdl_step = 0;
    endtask

    task automatic fill(input logic [W-1:0] c, output logic [W-1:0] v [0:N-1]);
        for (int i = 0; i < N; i++) v[i] = c;
    endtask

    // Presents v until the handshake; returns the edge number that took it.
    task automatic feed(input logic [W-1:0] v [0:N-1], output int hs);
        hs = -1;
        x_in = v;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && hs < 0; k++) begin
            if (in_ready) begin
                hs = cyc + 1;
                for (int i = 0; i < N; i++) mdl_h[i] = mdl_h[i] + v[i];
                mdl_step++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Returns the cycle in which out_valid is first seen, -1 on timeout.
    task automatic wait_out(output int oc);
        oc = -1;
        for (int k = 0; k < 40 && oc < 0; k++) begin
            if (out_valid) oc = cyc;
            else @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'h0000 || cell_x_t[i] !== 16'h0000 || cell_h_prev[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_vectors lane %0d: got h_out=%h x_t=%h h_prev=%h expected all 0000", i, h_out[i], cell_x_t[i], cell_h_prev[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] v [0:N-1];
        int hs [0:SL-1];
        int oc;
        fill(16'h0100, v);
        out_ready = 1'b1;
        for (int s = 0; s < SL; s++) begin
            feed(v, hs[s]);
            checks++; if (hs[s] < 0) begin errors++; $display("FAIL basic_handshake step %0d: got timeout expected handshake", s); end
            checks++; if (step !== 3'(mdl_step - 1)) begin errors++; $display("FAIL basic_step %0d: got %0d expected %0d", s, step, mdl_step - 1); end
            checks++; if (cell_x_t[3] !== 16'h0100) begin errors++; $display("FAIL basic_x_t: got %h expected 0100", cell_x_t[3]); end
            if (s > 0) begin
                checks++;
                if (hs[s] - hs[s-1] !== LAT + 1) begin errors++; $display("FAIL basic_spacing step %0d: got %0d expected %0d", s, hs[s] - hs[s-1], LAT + 1); end
            end
        end
        wait_out(oc);
        checks++; if (oc !== hs[SL-1] + LAT) begin errors++; $display("FAIL basic_out_cycle: got %0d expected %0d", oc, hs[SL-1] + LAT); end
        checks++; if (step !== 3'(SL)) begin errors++; $display("FAIL basic_final_step: got %0d expected %0d", step, SL); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'h0400) begin errors++; $display("FAIL basic_h_out lane %0d: got %h expected 0400", i, h_out[i]); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (step !== 3'd0 || h_out[0] !== 16'h0000) begin errors++; $display("FAIL basic_clear: got step=%0d h_out=%h expected 0 0000", step, h_out[0]); end
        mdl_clear();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v [0:N-1];
        logic [W-1:0] junk [0:N-1];
        int hs, oc;
        fill(16'h0100, v);
        fill(16'h7777, junk);
        out_ready = 1'b0;
        for (int s = 0; s < SL; s++) feed(v, hs);
        wait_out(oc);
        checks++; if (oc !== hs + LAT) begin errors++; $display("FAIL bp_out_cycle: got %0d expected %0d", oc, hs + LAT); end
        // Source offers a new vector while the output is blocked; it must be ignored.
        x_in = junk;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || step !== 3'(SL)) begin
                errors++; $display("FAIL bp_hold cycle %0d: got out_valid=%b in_ready=%b step=%0d expected 1 0 %0d", c, out_valid, in_ready, step, SL);
            end
            checks++;
            if (h_out[c % N] !== 16'h0400 || cell_x_t[c % N] !== 16'h0100) begin
                errors++; $display("FAIL bp_data cycle %0d: got h_out=%h x_t=%h expected 0400 0100", c, h_out[c % N], cell_x_t[c % N]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (h_out[5] !== 16'h0000 || step !== 3'd0) begin errors++; $display("FAIL bp_clear: got h_out=%h step=%0d expected 0000 0", h_out[5], step); end
        mdl_clear();
    endtask

    task automatic test_negative_restart();
        logic [W-1:0] seq_vals [0:SL-1];
        logic [W-1:0] v [0:N-1];
        int hs, oc;
        seq_vals[0] = 16'hFE00; seq_vals[1] = 16'h0100;
        seq_vals[2] = 16'h0100; seq_vals[3] = 16'hFF00;
        out_ready = 1'b1;
        for (int s = 0; s < SL; s++) begin
            fill(seq_vals[s], v);
            feed(v, hs);
        end
        wait_out(oc);
        checks++; if (oc < 0) begin errors++; $display("FAIL neg_out: got timeout expected out_valid"); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'hFF00) begin errors++; $display("FAIL neg_h_out lane %0d: got %h expected ff00", i, h_out[i]); end
        end
        mdl_clear();
        fill(16'h0010, v);
        for (int s = 0; s < SL; s++) feed(v, hs);
        wait_out(oc);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'h0040 || h_out[i] !== mdl_h[i]) begin errors++; $display("FAIL restart_h_out lane %0d: got %h expected 0040", i, h_out[i]); end
        end
        @(negedge clk);
        mdl_clear();
    endtask

    task automatic test_source_stall();
        logic [W-1:0] v [0:N-1];
        int hs, oc, t;
        fill(16'h0100, v);
        out_ready = 1'b1;
        feed(v, hs);
        feed(v, hs);
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (step !== 3'd2 || cell_h_prev[c] !== 16'h0200) begin
                errors++; $display("FAIL stall_hold cycle %0d: got step=%0d h_prev=%h expected 2 0200", c, step, cell_h_prev[c]);
            end
            @(negedge clk);
        end
        feed(v, hs);
        feed(v, hs);
        wait_out(oc);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'h0400) begin errors++; $display("FAIL stall_h_out lane %0d: got %h expected 0400", i, h_out[i]); end
        end
        @(negedge clk);
        mdl_clear();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v [0:N-1];
        int hs, oc;
        fill(16'h0100, v);
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) feed(v, hs);
        // Third step is now in its latency wait.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_clear();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || step !== 3'd0) begin
            errors++; $display("FAIL midwait_ctrl: got in_ready=%b out_valid=%b step=%0d expected 1 0 0", in_ready, out_valid, step);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'h0000 || cell_x_t[i] !== 16'h0000 || cell_h_prev[i] !== 16'h0000) begin
                errors++; $display("FAIL midwait_vectors lane %0d: got h_out=%h x_t=%h expected 0000", i, h_out[i], cell_x_t[i]);
            end
        end
        for (int s = 0; s < SL; s++) feed(v, hs);
        wait_out(oc);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (h_out[i] !== 16'h0400) begin errors++; $display("FAIL midwait_after lane %0d: got %h expected 0400", i, h_out[i]); end
        end
        @(negedge clk);
        // Reset while the result waits for the consumer drops it.
        out_ready = 1'b0;
        for (int s = 0; s < SL; s++) feed(v, hs);
        wait_out(oc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_clear();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || h_out[2] !== 16'h0000 || step !== 3'd0) begin
            errors++; $display("FAIL midout_reset: got out_valid=%b in_ready=%b h_out=%h step=%0d expected 0 1 0000 0", out_valid, in_ready, h_out[2], step);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v [0:N-1];
        int hs, prev, gap, oc, d, exp_hs;
        for (int q = 0; q < 6; q++) begin
            out_ready = 1'b0;
            prev = 0;
            for (int s = 0; s < SL; s++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                for (int i = 0; i < N; i++) v[i] = 16'($urandom);
                feed(v, hs);
                if (s > 0) begin
                    exp_hs = (prev + gap + 1 > prev + LAT + 1) ? prev + gap + 1 : prev + LAT + 1;
                    checks++;
                    if (hs !== exp_hs) begin errors++; $display("FAIL rand_handshake seq %0d step %0d: got %0d expected %0d", q, s, hs, exp_hs); end
                end
                prev = hs;
            end
            wait_out(oc);
            checks++; if (oc !== prev + LAT) begin errors++; $display("FAIL rand_out_cycle seq %0d: got %0d expected %0d", q, oc, prev + LAT); end
            checks++; if (step !== 3'(mdl_step)) begin errors++; $display("FAIL rand_step seq %0d: got %0d expected %0d", q, step, mdl_step); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (h_out[i] !== mdl_h[i]) begin errors++; $display("FAIL rand_h_out seq %0d lane %0d: got %h expected %h", q, i, h_out[i], mdl_h[i]); end
            end
            d = $urandom_range(0, 4);
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || h_out[c] !== mdl_h[c]) begin errors++; $display("FAIL rand_hold seq %0d: got out_valid=%b h_out=%h expected 1 %h", q, out_valid, h_out[c], mdl_h[c]); end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rand_accept seq %0d: got out_valid=%b in_ready=%b expected 0 1", q, out_valid, in_ready); end
            mdl_clear();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) x_in[i] = '0;
        mdl_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_negative_restart();
        test_source_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gru_sequencer.md
# gru_sequencer

Recurrence controller that drives `gruCell` over a time series. Accepts one input vector per timestep through a valid/ready handshake and presents it as `x_t` together with the stored hidden state as `h_t_minus_1`. After the cell's fixed pipeline latency it captures `h_t`, feeds it back for the next step, and emits the final hidden state once `SEQ_LEN` steps have completed. It sits between the feature/frame source and the downstream dense/classifier layers.

## Interface
- `WIDTH`, 32, signed fixed-point data width (matches cell).
- `NFRAC`, 10, fractional bits (pass-through only; no arithmetic here).
- `x_SIZE`, 32, input vector length d.
- `h_SIZE`, 32, hidden vector length e.
- `SEQ_LEN`, 8, timesteps per sequence, ≥1.
- `CELL_LATENCY`, 4, cycles from stable cell inputs to valid `cell_h_t`, ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `x_in` valid.
- `in_ready`  out  1  sequencer can accept a timestep.
- `x_in`  in  WIDTH×[0:x_SIZE-1]  input vector.
- `cell_x_t`  out  WIDTH×[0:x_SIZE-1]  to cell `x_t`.
- `cell_h_prev`  out  WIDTH×[0:h_SIZE-1]  to cell `h_t_minus_1`.
- `cell_h_t`  in  WIDTH×[0:h_SIZE-1]  from cell `h_t`.
- `out_valid`  out  1  `h_out` holds final state.
- `out_ready`  in  1  consumer accepts `h_out`.
- `h_out`  out  WIDTH×[0:h_SIZE-1]  final hidden state.
- `step`  out  $clog2(SEQ_LEN+1)  completed timesteps in the current sequence.

## Operation
- Registers: `x_reg`, `h_reg`, `lat_cnt`, `step`, FSM state. `cell_x_t = x_reg` and `cell_h_prev = h_reg`, both driven directly from registers. `h_out = h_reg`.
- States:
  - IDLE: `in_ready=1`. When `in_valid`, latch `x_in` into `x_reg`, set `lat_cnt=CELL_LATENCY-1`, go to WAIT.
  - WAIT: `in_ready=0`. Decrement `lat_cnt` each cycle. When `lat_cnt==0`, latch `cell_h_t` into `h_reg` and increment `step`. If the new `step==SEQ_LEN`, go to OUT; otherwise go to IDLE.
  - OUT: `out_valid=1`, `in_ready=0`. When `out_ready`, clear `h_reg` and `step` to 0 and go to IDLE.
- A sequence starts with `h_reg=0`. Only one sequence is in flight; no overlap.
- `x_reg` and `h_reg` are stable throughout WAIT. This gives the combinational-input cell a steady operand for its whole pipeline.
- `in_valid` is ignored outside IDLE. The source must hold `x_in` until it sees the handshake.
- `h_out` and `out_valid` stay stable in OUT until accepted; no drop, no overwrite.
- Values are raw two's complement; no rescaling or saturation in this block.

## Timing
- Reset (synchronous, takes effect at the edge): state IDLE, `in_ready=1`, `out_valid=0`, `x_reg=0`, `h_reg=0`, `step=0`, `lat_cnt=0`. Therefore `cell_x_t=0`, `cell_h_prev=0`, `h_out=0`.
- `in_ready` and `out_valid` are decoded from state only. No combinational path from `in_valid` or `out_ready`.
- Handshake at edge T puts `x_in` on `cell_x_t` from T+1. `cell_h_t` is sampled at edge T+CELL_LATENCY. The sequencer returns to IDLE (`in_ready=1`) in cycle T+CELL_LATENCY.
- Per-step throughput: one step per CELL_LATENCY+1 cycles, given `in_valid` held high.
- Final step: `out_valid` rises in cycle T+CELL_LATENCY. If `out_ready` is already high, acceptance happens at that edge and `in_ready` returns the next cycle.
- `SEQ_LEN=1`: every accepted input goes IDLE→WAIT→OUT.
- Reset mid-WAIT or mid-OUT: partial sequence and pending output are discarded. Next sequence starts with `h=0`.
- `step` counts from 0 to SEQ_LEN with no wrap. It returns to 0 only on output acceptance or reset.

## Test plan
Bench uses a behavioural cell stub: `h_t[i] = h_prev[i] + x_t[i]`, registered with CELL_LATENCY delay. Parameters: WIDTH=16, NFRAC=12, x_SIZE=h_SIZE=8, SEQ_LEN=4, CELL_LATENCY=3.
- Reset check: assert `reset` for 2 cycles → `in_ready=1`, `out_valid=0`, `h_out` all 0, `step=0`.
- Basic sequence: feed `x_in[i]=16'h0100` for 4 steps with `in_valid` held and `out_ready=1` → `out_valid` one cycle, `h_out[i]=16'h0400`; steps spaced 4 cycles apart.
- Backpressure: same input with `out_ready=0` for 10 cycles → `out_valid` and `h_out=16'h0400` held stable, `in_ready=0`; then `out_ready=1` → accepted, `in_ready=1` next cycle.
- Negative values and restart: sequence `x=-0x0200,0x0100,0x0100,-0x0100`, then a second sequence of `0x0010`×4 → first output `16'hFF00`, second `16'h0040` (confirms `h` cleared between sequences).
- Source stalls: `in_valid` low for 5 cycles between steps 2 and 3 → `step` holds at 2, `cell_h_prev` unchanged, final result still correct.
- Reset mid-WAIT on step 3 → all outputs at reset values. A following full sequence of `0x0100` yields `16'h0400`.
